// File: rtl/cpu_pkg.sv
// Shared types and default addresses for the Harvard MIPS core sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    EXEC   = 2'b00,
    STALL  = 2'b01,
    HALTED = 2'b11
  } seq_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEFAULT    = 32'h0000_0000;

endpackage

// File: rtl/seq_delay_slot.sv
// Branch/jump delay-slot tracker: remembers a taken target until the delay slot
// retires, then supplies it as the next pc and flags a transfer to HALT_ADDR.
module seq_delay_slot
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        retire_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        halt_hit_o
);

  logic        pending_q, pending_d;
  logic [31:0] target_q, target_d;

  always_comb begin
    pending_d = pending_q;
    target_d  = target_q;
    if (retire_i) begin
      // A delay-slot instruction's own redirect is dropped.
      if (pending_q) begin
        pending_d = 1'b0;
      end else if (redirect_i) begin
        pending_d = 1'b1;
        target_d  = target_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 1'b0;
      target_q  <= 32'h0;
    end else begin
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign next_pc_o  = pending_q ? target_q : pc_i + 32'd4;
  assign halt_hit_o = pending_q && (target_q == HALT_ADDR);

endmodule

// File: rtl/cpu_sequencer.sv
// Program counter and EXEC/STALL/HALTED sequencing for the Harvard MIPS core.
// Optional perf counters are built when SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        redirect,
  input  logic [31:0] target,
  input  logic        md_req,
  input  logic        md_busy,
  output logic [31:0] pc,
  output logic        commit,
  output logic        active,
  output logic [1:0]  state,
  output logic [31:0] cycle_count,
  output logic [31:0] retire_count
);

  seq_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc;
  logic        halt_hit;
  logic        md_stall;

  assign md_stall = md_req && md_busy;
  assign commit   = (state_q == EXEC) && clk_enable && !md_stall;

  seq_delay_slot #(
    .HALT_ADDR (HALT_ADDR)
  ) u_delay_slot (
    .clk        (clk),
    .reset      (reset),
    .retire_i   (commit),
    .redirect_i (redirect),
    .target_i   (target),
    .pc_i       (pc_q),
    .next_pc_o  (next_pc),
    .halt_hit_o (halt_hit)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      EXEC: begin
        if (clk_enable) begin
          if (md_stall) begin
            state_d = STALL;
          end else begin
            pc_d = next_pc;
            if (halt_hit) state_d = HALTED;
          end
        end
      end
      STALL: begin
        // The stalled instruction re-executes and commits from EXEC.
        if (clk_enable && !md_busy) state_d = EXEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EXEC;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign state  = state_q;
  assign active = (state_q != HALTED);

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_q, retire_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q  <= 32'h0;
      retire_q <= 32'h0;
    end else begin
      if (clk_enable && (state_q != HALTED)) cycle_q <= cycle_q + 32'd1;
      if (commit) retire_q <= retire_q + 32'd1;
    end
  end

  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;
`else
  assign cycle_count  = 32'h0;
  assign retire_count = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table plus hand sequences.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_enable, redirect, md_req, md_busy;
  logic [31:0] target;
  logic [31:0] pc, cycle_count, retire_count;
  logic        commit, active;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .redirect     (redirect),
    .target       (target),
    .md_req       (md_req),
    .md_busy      (md_busy),
    .pc           (pc),
    .commit       (commit),
    .active       (active),
    .state        (state),
    .cycle_count  (cycle_count),
    .retire_count (retire_count)
  );

  typedef struct {
    logic        rst, ce, rd, mr, mb, chk;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_commit, e_active;
    logic [1:0]  e_state;
  } vec_t;

  vec_t tbl[64];
  int   n = 0;

  localparam logic [31:0] R = 32'hBFC0_0000;

  task automatic add(input logic rst, ce, rd, input logic [31:0] tgt, input logic mr, mb, chk,
                     input logic [31:0] epc, input logic ecm, eac, input logic [1:0] est);
    tbl[n].rst = rst; tbl[n].ce = ce; tbl[n].rd = rd; tbl[n].tgt = tgt;
    tbl[n].mr = mr; tbl[n].mb = mb; tbl[n].chk = chk;
    tbl[n].e_pc = epc; tbl[n].e_commit = ecm; tbl[n].e_active = eac; tbl[n].e_state = est;
    n++;
  endtask

  task automatic drive(input logic rst, ce, rd, input logic [31:0] tgt, input logic mr, mb);
    reset = rst; clk_enable = ce; redirect = rd; target = tgt; md_req = mr; md_busy = mb;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic ecm, eac,
                           input logic [1:0] est);
    check({tag, ".pc"}, pc, epc);
    check({tag, ".commit"}, {31'h0, commit}, {31'h0, ecm});
    check({tag, ".active"}, {31'h0, active}, {31'h0, eac});
    check({tag, ".state"}, {30'h0, state}, {30'h0, est});
  endtask

  initial begin
    // Straight-line fetch after reset.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h00, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h04, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h08, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h0C, 1, 1, 2'b00);
    // Multiply/divide stall at 0x10 for four busy cycles.
    add(0, 1, 0, 0, 1, 1, 1, R + 32'h10, 0, 1, 2'b00);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 1, 1, 1, R + 32'h10, 0, 1, 2'b01);
    add(0, 1, 0, 0, 1, 0, 1, R + 32'h10, 0, 1, 2'b01);
    add(0, 1, 0, 0, 1, 0, 1, R + 32'h10, 1, 1, 2'b00);
    // Branch with delay slot; the slot's own redirect is ignored.
    add(0, 1, 1, R + 32'h100, 0, 0, 1, R + 32'h14, 1, 1, 2'b00);
    add(0, 1, 1, 32'h1234_5678, 0, 0, 1, R + 32'h18, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h100, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h104, 1, 1, 2'b00);
    // Freeze between a redirect and its delay slot.
    add(0, 1, 1, R + 32'h200, 0, 0, 1, R + 32'h108, 1, 1, 2'b00);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 1, 1, 1, R + 32'h10C, 0, 1, 2'b00);
    add(0, 1, 1, 0, 0, 0, 1, R + 32'h10C, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h200, 1, 1, 2'b00);
    // Jump to HALT_ADDR, delay slot retires, then halted for good.
    add(0, 1, 1, 0, 0, 0, 1, R + 32'h204, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0, 0, 1, R + 32'h208, 1, 1, 2'b00);
    for (int i = 0; i < 11; i++)
      add(0, 1, i[0], R + 32'h300, 1, i[1], 1, 32'h0, 0, 0, 2'b11);

    for (int i = 0; i < n; i++) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].rd, tbl[i].tgt, tbl[i].mr, tbl[i].mb);
      #2;
      if (tbl[i].chk)
        check_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_commit, tbl[i].e_active,
                  tbl[i].e_state);
      @(negedge clk);
    end

    // Reset wins over clk_enable=0 and leaves HALTED.
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 1, R + 32'h80, 0, 0);
    #2;
    check_all("rst_ce0", R, 1, 1, 2'b00);
    check("rst_cyc", cycle_count, 32'h0);
    check("rst_ret", retire_count, 32'h0);
    @(negedge clk);
    // Delay slot stalls on md, then reset lands mid-stall.
    drive(0, 1, 0, 0, 1, 1);
    #2;
    check_all("ds_stall0", R + 32'h04, 0, 1, 2'b00);
`ifdef SEQ_PERF_CNT_EN
    check("perf_cyc", cycle_count, 32'd1);
    check("perf_ret", retire_count, 32'd1);
`else
    check("perf_cyc", cycle_count, 32'h0);
    check("perf_ret", retire_count, 32'h0);
`endif
    @(negedge clk);
    #2;
    check_all("ds_stall1", R + 32'h04, 0, 1, 2'b01);
    @(negedge clk);
    drive(1, 1, 0, 0, 1, 1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0);
    #2;
    check_all("stall_rst", R, 1, 1, 2'b00);
    @(negedge clk);
    #2;
    check_all("no_stale0", R + 32'h04, 1, 1, 2'b00);
    @(negedge clk);
    // Redirect to the top of the address space; pc+4 wraps to 0 without halting.
    drive(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    #2;
    check_all("no_stale1", R + 32'h08, 1, 1, 2'b00);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    check_all("wrap_top", 32'hFFFF_FFFC, 1, 1, 2'b00);
    @(negedge clk);
    #2;
    check_all("wrap_zero", 32'h0, 1, 1, 2'b00);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
